mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one multi-cycle memory port between instruction fetch (I-side, read-only) and the memory stage (D-side, load/store).
- Sequences each transaction through a small FSM and drives the fetch and memory-stage stall signals (stall_f_o, stall_m_o) into the hazard logic.
- D-side has priority; a bounded starvation counter guarantees I-side progress.
- Sits between the fetch/memory pipeline stages and the cache/memory interface.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- MAX_I_WAIT, 4, consecutive arbitration losses after which I-side wins (legal range 1..15).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- i_req_i  input  1  fetch request, level, held until i_ready_o.
- i_addr_i  input  ADDR_W  fetch address.
- i_rdata_o  output  DATA_W  fetch data, valid when i_ready_o.
- i_ready_o  output  1  fetch completion pulse.
- d_req_i  input  1  data request, level, held until d_ready_o.
- d_we_i  input  1  1 = store, 0 = load.
- d_addr_i  input  ADDR_W  data address.
- d_wdata_i  input  DATA_W  store data.
- d_rdata_o  output  DATA_W  load data, valid when d_ready_o.
- d_ready_o  output  1  data completion pulse.
- mem_req_o  output  1  memory request, held for the whole transaction.
- mem_we_o  output  1  memory write enable.
- mem_addr_o  output  ADDR_W  memory address.
- mem_wdata_o  output  DATA_W  memory write data.
- mem_rdata_i  input  DATA_W  memory read data, valid with mem_ready_i.
- mem_ready_i  input  1  memory completion, one-cycle pulse.
- stall_f_o  output  1  stall fetch stage.
- stall_m_o  output  1  stall memory stage.

Behaviour:
- Reset (asynchronous, rst_i=0) takes effect immediately:
  - state = ARB_IDLE, starvation counter = 0, latched addr/we/wdata = 0.
  - All outputs 0 while in reset.
- State ARB_IDLE: arbitration on the registered state; the grant takes effect at the next edge.
  - Only d_req_i set: go to ARB_SERVE_D.
  - Only i_req_i set: go to ARB_SERVE_I.
  - Both set: D wins unless the counter equals MAX_I_WAIT, in which case I wins.
  - On any grant, latch the winner's addr, we (forced 0 for I) and wdata.
- Starvation counter:
  - Increments (saturating at MAX_I_WAIT) on each IDLE grant to D while i_req_i=1.
  - Clears on every I grant.
- States ARB_SERVE_I / ARB_SERVE_D:
  - mem_req_o = 1; mem_addr_o/mem_we_o/mem_wdata_o come from the latched registers, stable for the whole transaction.
  - Wait for mem_ready_i. On that cycle, x_ready_o = mem_ready_i & x_req_i (combinational) and x_rdata_o = mem_rdata_i.
  - Next state is ARB_IDLE.
- Outside a completion cycle, rdata outputs are 0.
- Latency:
  - Request seen in IDLE at cycle 0; mem_req_o high from cycle 1.
  - With memory ready at cycle k≥1, x_ready_o is at cycle k.
  - A minimum of one IDLE cycle separates transactions, so back-to-back throughput is one per (memory latency + 1) cycles.
- Stalls: stall_f_o = i_req_i & ~i_ready_o; stall_m_o = d_req_i & ~d_ready_o. Both are combinational.
- Requester drops req mid-transaction (flush): the memory transaction still completes (it cannot be aborted), the ready pulse is suppressed and the data is discarded.
- Requester raises req during the other side's service: it waits; its stall is asserted throughout.
- mem_ready_i in IDLE is ignored (protocol error; add an assertion in the bench).
- Reset mid-transaction: mem_req_o drops asynchronously; the memory side must tolerate the abandoned request.

Decomposition:
- Package mem_arb_pkg holds:
  - enum arb_state_e {ARB_IDLE, ARB_SERVE_I, ARB_SERVE_D} (2 bits).
  - localparam for the counter width, $clog2(MAX_I_WAIT+1), computed in the module from the parameter.
- No sub-module: FSM, latch registers and counter are small enough to live in one module.

Test Plan:
- Single load: d_req=1, d_addr=0x100, memory returns 0xDEADBEEF after 3 cycles. Expect mem_req_o high cycles 1–3, mem_addr_o=0x100, mem_we_o=0, d_ready_o and d_rdata_o=0xDEADBEEF at cycle 3, stall_m_o high cycles 0–2.
- Store: d_we=1, d_addr=0x20, d_wdata=0x1234 with 1-cycle memory. Expect mem_we_o=1, mem_wdata_o=0x1234 at cycle 1, d_ready_o at cycle 1, stall_f_o unaffected.
- Simultaneous: i_req and d_req both high. Expect D served first, I granted in the following IDLE; stall_f_o high until i_ready_o.
- Starvation, MAX_I_WAIT=4: i_req held high and d_req held continuously (new address each completion). Expect exactly 4 D transactions, then an I grant, then the counter returns to 0.
- Flush: deassert i_req_i during ARB_SERVE_I. Expect mem_req_o held until mem_ready_i, i_ready_o stays 0, FSM returns to IDLE.
- Reset mid-transaction: assert rst_i=0 during ARB_SERVE_D. Expect mem_req_o=0 in the same cycle (asynchronous), state IDLE, counter 0; normal operation after release.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM state encoding.
package mem_arb_pkg;

   localparam int unsigned ARB_STATE_W = 2;

   typedef enum logic [ARB_STATE_W-1:0] {
      ARB_IDLE    = 2'd0,
      ARB_SERVE_I = 2'd1,
      ARB_SERVE_D = 2'd2
   } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one multi-cycle memory port between instruction fetch and the memory stage.
// D-side has priority; a saturating loss counter forces an I grant after MAX_I_WAIT losses.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned MAX_I_WAIT = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              i_req_i,
   input  logic [ADDR_W-1:0] i_addr_i,
   output logic [DATA_W-1:0] i_rdata_o,
   output logic              i_ready_o,
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [DATA_W-1:0] d_wdata_i,
   output logic [DATA_W-1:0] d_rdata_o,
   output logic              d_ready_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              mem_ready_i,
   output logic              stall_f_o,
   output logic              stall_m_o
);

   localparam int unsigned      CNT_W   = $clog2(MAX_I_WAIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_I_WAIT);

   arb_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              grant_i, grant_d;
   logic              i_starved;
   logic              serving;

   assign i_starved = i_req_i && (cnt_q == CNT_MAX);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      grant_i = 1'b0;
      grant_d = 1'b0;
      unique case (state_q)
         ARB_IDLE: begin
            if (d_req_i && !i_starved) begin
               grant_d = 1'b1;
            end else if (i_req_i) begin
               grant_i = 1'b1;
            end
            if (grant_d) begin
               state_d = ARB_SERVE_D;
               addr_d  = d_addr_i;
               we_d    = d_we_i;
               wdata_d = d_wdata_i;
               // Count only losses that actually delayed a pending fetch.
               if (i_req_i && (cnt_q != CNT_MAX)) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else if (grant_i) begin
               state_d = ARB_SERVE_I;
               addr_d  = i_addr_i;
               we_d    = 1'b0;
               wdata_d = '0;
               cnt_d   = '0;
            end
         end
         ARB_SERVE_I, ARB_SERVE_D: begin
            if (mem_ready_i) begin
               state_d = ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= ARB_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
      end
   end

   assign serving     = (state_q != ARB_IDLE);
   assign mem_req_o   = serving;
   assign mem_we_o    = serving && we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;

   // A dropped request (flush) suppresses the pulse and the data.
   assign i_ready_o = (state_q == ARB_SERVE_I) && mem_ready_i && i_req_i;
   assign d_ready_o = (state_q == ARB_SERVE_D) && mem_ready_i && d_req_i;
   assign i_rdata_o = i_ready_o ? mem_rdata_i : '0;
   assign d_rdata_o = d_ready_o ? mem_rdata_i : '0;

   // Gated by reset so every output is 0 while reset is held.
   assign stall_f_o = rst_i && i_req_i && !i_ready_o;
   assign stall_m_o = rst_i && d_req_i && !d_ready_o;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: table of single transactions plus
// hand-written multi-cycle sequences (contention, starvation, flush, reset).
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        i_req_i;
   logic [31:0] i_addr_i;
   logic [31:0] i_rdata_o;
   logic        i_ready_o;
   logic        d_req_i;
   logic        d_we_i;
   logic [31:0] d_addr_i;
   logic [31:0] d_wdata_i;
   logic [31:0] d_rdata_o;
   logic        d_ready_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [31:0] mem_rdata_i;
   logic        mem_ready_i;
   logic        stall_f_o;
   logic        stall_m_o;

   int checks = 0;
   int errors = 0;

   mem_port_arbiter #(
      .ADDR_W    (32),
      .DATA_W    (32),
      .MAX_I_WAIT(4)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst_i),
      .i_req_i    (i_req_i),
      .i_addr_i   (i_addr_i),
      .i_rdata_o  (i_rdata_o),
      .i_ready_o  (i_ready_o),
      .d_req_i    (d_req_i),
      .d_we_i     (d_we_i),
      .d_addr_i   (d_addr_i),
      .d_wdata_i  (d_wdata_i),
      .d_rdata_o  (d_rdata_o),
      .d_ready_o  (d_ready_o),
      .mem_req_o  (mem_req_o),
      .mem_we_o   (mem_we_o),
      .mem_addr_o (mem_addr_o),
      .mem_wdata_o(mem_wdata_o),
      .mem_rdata_i(mem_rdata_i),
      .mem_ready_i(mem_ready_i),
      .stall_f_o  (stall_f_o),
      .stall_m_o  (stall_m_o)
   );

   always #5 clk = ~clk;

   // Protocol: memory may only complete while a request is outstanding.
   always @(negedge clk) begin
      if (rst_i && mem_ready_i) begin
         assert (mem_req_o)
         else begin
            errors++;
            $display("FAIL mem_ready_in_idle: mem_req_o=%0b required 1 at %0t", mem_req_o, $time);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish before 200000");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        d_req;
      logic        d_we;
      logic [31:0] d_addr;
      logic [31:0] d_wdata;
      logic        i_req;
      logic [31:0] i_addr;
      int          lat;
      logic [31:0] mem_data;
      logic        exp_d;
      logic [31:0] exp_addr;
      logic        exp_we;
      logic [31:0] exp_wdata;
   } vec_t;

   vec_t vecs[6];

   function automatic vec_t mk(input logic dr, input logic dwe, input logic [31:0] da,
                               input logic [31:0] dwd, input logic ir, input logic [31:0] ia,
                               input int lat, input logic [31:0] md, input logic ed,
                               input logic [31:0] ea, input logic ewe, input logic [31:0] ewd);
      vec_t v;
      v.d_req = dr; v.d_we = dwe; v.d_addr = da; v.d_wdata = dwd;
      v.i_req = ir; v.i_addr = ia; v.lat = lat; v.mem_data = md;
      v.exp_d = ed; v.exp_addr = ea; v.exp_we = ewe; v.exp_wdata = ewd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drop_all();
      i_req_i = 1'b0; d_req_i = 1'b0; d_we_i = 1'b0;
      i_addr_i = '0; d_addr_i = '0; d_wdata_i = '0;
      mem_ready_i = 1'b0; mem_rdata_i = '0;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      string tag;
      tag = $sformatf("vec%0d", idx);
      @(posedge clk); #1;
      d_req_i = v.d_req; d_we_i = v.d_we; d_addr_i = v.d_addr; d_wdata_i = v.d_wdata;
      i_req_i = v.i_req; i_addr_i = v.i_addr;
      mem_ready_i = 1'b0; mem_rdata_i = '0;
      @(negedge clk);
      chk({tag, "_c0_mem_req"}, 32'(mem_req_o), 32'd0);
      chk({tag, "_c0_stall_m"}, 32'(stall_m_o), 32'(v.d_req));
      chk({tag, "_c0_stall_f"}, 32'(stall_f_o), 32'(v.i_req));
      for (int c = 1; c <= v.lat; c++) begin
         @(posedge clk); #1;
         mem_ready_i = (c == v.lat);
         mem_rdata_i = (c == v.lat) ? v.mem_data : 32'h0;
         @(negedge clk);
         chk({tag, "_mem_req"}, 32'(mem_req_o), 32'd1);
         chk({tag, "_mem_addr"}, mem_addr_o, v.exp_addr);
         chk({tag, "_mem_we"}, 32'(mem_we_o), 32'(v.exp_we));
         chk({tag, "_mem_wdata"}, mem_wdata_o, v.exp_wdata);
         if (c == v.lat) begin
            chk({tag, "_d_ready"}, 32'(d_ready_o), 32'(v.exp_d));
            chk({tag, "_i_ready"}, 32'(i_ready_o), 32'(!v.exp_d));
            chk({tag, "_d_rdata"}, d_rdata_o, v.exp_d ? v.mem_data : 32'h0);
            chk({tag, "_i_rdata"}, i_rdata_o, v.exp_d ? 32'h0 : v.mem_data);
            chk({tag, "_stall_m"}, 32'(stall_m_o), 32'(v.d_req && !v.exp_d));
            chk({tag, "_stall_f"}, 32'(stall_f_o), 32'(v.i_req && v.exp_d));
         end else begin
            chk({tag, "_d_ready_early"}, 32'(d_ready_o), 32'd0);
            chk({tag, "_i_ready_early"}, 32'(i_ready_o), 32'd0);
            chk({tag, "_d_rdata_early"}, d_rdata_o, 32'h0);
            chk({tag, "_stall_m"}, 32'(stall_m_o), 32'(v.d_req));
         end
      end
      @(posedge clk); #1;
      drop_all();
      @(negedge clk);
      chk({tag, "_back_idle"}, 32'(mem_req_o), 32'd0);
   endtask

   // Both sides request continuously with 1-cycle memory; every fifth grant goes to I.
   task automatic run_contend(input string tag, input int n);
      logic exp_i;
      @(posedge clk); #1;
      i_req_i = 1'b1; i_addr_i = 32'h800;
      d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h1000;
      for (int j = 0; j < n; j++) begin
         exp_i = ((j % 5) == 4);
         @(negedge clk);
         chk($sformatf("%s_idle%0d", tag, j), 32'(mem_req_o), 32'd0);
         @(posedge clk); #1;
         mem_ready_i = 1'b1; mem_rdata_i = 32'(j);
         @(negedge clk);
         chk($sformatf("%s_addr%0d", tag, j), mem_addr_o, exp_i ? 32'h800 : d_addr_i);
         chk($sformatf("%s_i_ready%0d", tag, j), 32'(i_ready_o), 32'(exp_i));
         chk($sformatf("%s_d_ready%0d", tag, j), 32'(d_ready_o), 32'(!exp_i));
         chk($sformatf("%s_stall_f%0d", tag, j), 32'(stall_f_o), 32'(!exp_i));
         @(posedge clk); #1;
         mem_ready_i = 1'b0; mem_rdata_i = '0;
         if (!exp_i) d_addr_i = d_addr_i + 32'd4;
      end
      drop_all();
   endtask

   initial begin
      vecs[0] = mk(1, 0, 32'h100, 32'h0,    0, 32'h0,   3, 32'hDEADBEEF, 1, 32'h100, 0, 32'h0);
      vecs[1] = mk(1, 1, 32'h20,  32'h1234, 0, 32'h0,   1, 32'hA5A5,     1, 32'h20,  1, 32'h1234);
      vecs[2] = mk(0, 0, 32'h0,   32'h0,    1, 32'h400, 2, 32'h13,       0, 32'h400, 0, 32'h0);
      vecs[3] = mk(1, 0, 32'h30,  32'h0,    1, 32'h500, 2, 32'h77,       1, 32'h30,  0, 32'h0);
      // Stray d_we/d_wdata while only I requests must not leak into the fetch.
      vecs[4] = mk(0, 1, 32'h0,   32'hFFFF, 1, 32'h600, 1, 32'h66,       0, 32'h600, 0, 32'h0);
      vecs[5] = mk(1, 1, 32'h40,  32'hBEEF, 1, 32'h700, 1, 32'h55,       1, 32'h40,  1, 32'hBEEF);

      rst_i = 1'b0;
      drop_all();
      i_req_i = 1'b1; d_req_i = 1'b1; d_addr_i = 32'h44;
      @(negedge clk); @(negedge clk);
      chk("rst_mem_req", 32'(mem_req_o), 32'd0);
      chk("rst_mem_addr", mem_addr_o, 32'h0);
      chk("rst_mem_we", 32'(mem_we_o), 32'd0);
      chk("rst_stall_f", 32'(stall_f_o), 32'd0);
      chk("rst_stall_m", 32'(stall_m_o), 32'd0);
      chk("rst_ready", 32'({i_ready_o, d_ready_o}), 32'd0);
      @(posedge clk); #1;
      drop_all();
      rst_i = 1'b1;

      for (int k = 0; k < 6; k++) run_vec(vecs[k], k);

      // Simultaneous: D first, I in the following IDLE, stall_f held until i_ready.
      @(posedge clk); #1;
      d_req_i = 1'b1; d_addr_i = 32'h50; i_req_i = 1'b1; i_addr_i = 32'h880;
      @(negedge clk);
      chk("sim_c0_stall_f", 32'(stall_f_o), 32'd1);
      @(posedge clk); #1;
      mem_ready_i = 1'b1; mem_rdata_i = 32'hD0;
      @(negedge clk);
      chk("sim_c1_addr", mem_addr_o, 32'h50);
      chk("sim_c1_d_ready", 32'(d_ready_o), 32'd1);
      chk("sim_c1_stall_f", 32'(stall_f_o), 32'd1);
      @(posedge clk); #1;
      mem_ready_i = 1'b0; d_req_i = 1'b0;
      @(negedge clk);
      chk("sim_c2_mem_req", 32'(mem_req_o), 32'd0);
      chk("sim_c2_stall_f", 32'(stall_f_o), 32'd1);
      @(posedge clk); #1;
      mem_ready_i = 1'b1; mem_rdata_i = 32'hF0;
      @(negedge clk);
      chk("sim_c3_addr", mem_addr_o, 32'h880);
      chk("sim_c3_i_ready", 32'(i_ready_o), 32'd1);
      chk("sim_c3_i_rdata", i_rdata_o, 32'hF0);
      chk("sim_c3_stall_f", 32'(stall_f_o), 32'd0);
      @(posedge clk); #1;
      drop_all();

      run_contend("starve", 10);

      // Flush: fetch dropped mid-transaction still runs to mem_ready, no pulse.
      @(posedge clk); #1;
      i_req_i = 1'b1; i_addr_i = 32'h900;
      @(negedge clk);
      chk("flush_c0_stall_f", 32'(stall_f_o), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("flush_c1_addr", mem_addr_o, 32'h900);
      @(posedge clk); #1;
      i_req_i = 1'b0;
      @(negedge clk);
      chk("flush_c2_mem_req", 32'(mem_req_o), 32'd1);
      chk("flush_c2_stall_f", 32'(stall_f_o), 32'd0);
      @(posedge clk); #1;
      mem_ready_i = 1'b1; mem_rdata_i = 32'h99;
      @(negedge clk);
      chk("flush_c3_mem_req", 32'(mem_req_o), 32'd1);
      chk("flush_c3_i_ready", 32'(i_ready_o), 32'd0);
      chk("flush_c3_i_rdata", i_rdata_o, 32'h0);
      @(posedge clk); #1;
      drop_all();
      @(negedge clk);
      chk("flush_idle", 32'(mem_req_o), 32'd0);

      // Reset mid-transaction after a contended D grant has bumped the counter.
      @(posedge clk); #1;
      d_req_i = 1'b1; d_addr_i = 32'hA0; i_req_i = 1'b1; i_addr_i = 32'hB0;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rmid_mem_req_before", 32'(mem_req_o), 32'd1);
      chk("rmid_addr_before", mem_addr_o, 32'hA0);
      #2;
      rst_i = 1'b0;
      #1;
      chk("rmid_mem_req_async", 32'(mem_req_o), 32'd0);
      chk("rmid_mem_addr_async", mem_addr_o, 32'h0);
      chk("rmid_stall_m_async", 32'(stall_m_o), 32'd0);
      @(posedge clk); #1;
      drop_all();
      rst_i = 1'b1;
      @(negedge clk);
      chk("rmid_idle_after", 32'(mem_req_o), 32'd0);

      run_contend("post_rst", 10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
